axis_interruption_injector: RTL and testbench

- Synthesizable AXI-Stream pass-through that inserts programmable bubbles (interruptions) into a packet, parametrised in data width, stall length and LFSR width.
- Sits between a stream source and sink in the AXI model testbench and in FPGA soak builds.
- Interruptions are biased toward packet head and tail beats, plus random mid-packet bursts, all bounded by a per-packet stall-cycle budget.
- Deterministic from a loadable seed.

---
 rtl/axis_interruption_pkg.sv | 27 ++
 rtl/axis_interruption_injector_lfsr.sv | 24 ++
 rtl/axis_interruption_injector.sv | 143 ++++++++++++++
 tb/tb_axis_interruption_injector.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_interruption_pkg.sv
// Shared types and constants for the AXI-Stream interruption injector.
// edge_threshold gives the head/tail stall threshold for a beat index, or 0 when the beat is not an edge beat.
package axis_interruption_pkg;

  typedef enum logic {PASS = 1'b0, STALL = 1'b1} state_e;

  localparam logic [10:0] HEAD_THR_1   = 11'd128;
  localparam logic [10:0] HEAD_THR_2   = 11'd256;
  localparam logic [10:0] HEAD_THR_3   = 11'd512;
  localparam logic [10:0] TAIL_THR     = 11'd512;
  localparam logic [10:0] FORCE_THR    = 11'd1024;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [10:0] edge_threshold(input logic [31:0] k,
                                                 input logic [31:0] len,
                                                 input logic        force_edges);
    logic [10:0] thr;
    thr = '0;
    if (k == 32'd1)      thr = HEAD_THR_1;
    else if (k == 32'd2) thr = HEAD_THR_2;
    else if (k == 32'd3) thr = HEAD_THR_3;
    else if (k != 32'd0 && k < len && k + 32'd3 >= len) thr = TAIL_THR;
    if (thr != '0 && force_edges) thr = FORCE_THR;
    return thr;
  endfunction

endpackage

// File: rtl/axis_interruption_injector_lfsr.sv
// Right-shifting Galois LFSR that advances every cycle; a seed load takes priority
// and a zero seed is swapped for the default so the register never locks up.
module lfsr_galois #(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= DEFAULT_SEED;
    else if (seed_load)
      state <= (seed == '0) ? DEFAULT_SEED : seed;
    else
      state <= {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? TAPS : '0);
  end

endmodule

// File: rtl/axis_interruption_injector.sv
// AXI-Stream pass-through that inserts LFSR-driven bubbles biased to packet head/tail
// beats plus mid-packet bursts, limited by a per-packet stall-cycle budget.
module axis_interruption_injector #(
  parameter int                DATA_W       = 32,
  parameter int                MAX_INT_LEN  = 16,
  parameter int                LEN_W        = 16,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(axis_interruption_pkg::DEFAULT_SEED)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  input  logic              cfg_en,
  input  logic [LEN_W-1:0]  cfg_pkt_len,
  input  logic [LEN_W-1:0]  cfg_budget,
  input  logic [5:0]        cfg_max_len,
  input  logic [10:0]       cfg_rate,
  input  logic              cfg_edge_en,
  input  logic              cfg_force_edges,
  input  logic [LFSR_W-1:0] cfg_seed,
  input  logic              cfg_seed_load,
  output logic              stall_active,
  output logic [31:0]       stall_cycles_total,
  output logic [31:0]       pkt_count
);

  import axis_interruption_pkg::*;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  k_q, k_next, budget_q, pkt_len_q;
  logic [5:0]        cnt_q, max_len_q;
  logic [10:0]       rate_q;
  logic              edge_en_q, force_q;
  logic [LFSR_W-1:0] lfsr;

  logic              stall, hs, pkt_start, take_stall;
  logic [LEN_W-1:0]  eff_len, eff_budget;
  logic [5:0]        eff_max_len, max_cap, len_raw, stall_len;
  logic [10:0]       eff_rate, edge_thr, thr;
  logic              eff_edge_en, eff_force, in_mid;

  lfsr_galois #(
    .LFSR_W       (LFSR_W),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk       (aclk),
    .rst_n     (aresetn),
    .seed_load (cfg_seed_load),
    .seed      (cfg_seed),
    .state     (lfsr)
  );

  assign stall        = (state_q == STALL);
  assign stall_active = stall;
  assign m_tvalid     = s_tvalid & ~stall;
  assign s_tready     = m_tready & ~stall;
  assign m_tdata      = s_tdata;
  assign m_tlast      = s_tlast;
  assign hs           = s_tvalid & m_tready & ~stall;
  assign pkt_start    = hs & (k_q == '0);
  assign k_next       = (k_q == '1) ? k_q : k_q + LEN_W'(1);

  // Beat 0's handshake both latches the packet config and decides beat 1, so use the live cfg then
  assign eff_len     = pkt_start ? cfg_pkt_len     : pkt_len_q;
  assign eff_budget  = pkt_start ? cfg_budget      : budget_q;
  assign eff_max_len = pkt_start ? cfg_max_len     : max_len_q;
  assign eff_rate    = pkt_start ? cfg_rate        : rate_q;
  assign eff_edge_en = pkt_start ? cfg_edge_en     : edge_en_q;
  assign eff_force   = pkt_start ? cfg_force_edges : force_q;

  always_comb begin
    edge_thr = edge_threshold(32'(k_next), 32'(eff_len), eff_force);
    in_mid   = (k_next >= LEN_W'(4)) &&
               ((LEN_W+1)'(k_next) + (LEN_W+1)'(4) <= (LEN_W+1)'(eff_len));
    max_cap  = (eff_max_len == '0) ? 6'd1 :
               (eff_max_len > 6'(MAX_INT_LEN)) ? 6'(MAX_INT_LEN) : eff_max_len;
    thr      = '0;
    len_raw  = 6'd1;
    if (eff_edge_en && edge_thr != '0) begin
      thr = edge_thr;
    end else if (in_mid) begin
      thr     = eff_rate;
      len_raw = 6'd1 + (lfsr[15:10] % max_cap);
    end
    take_stall = cfg_en & hs & ~s_tlast & ({1'b0, lfsr[9:0]} < thr) & (eff_budget != '0);
    stall_len  = (LEN_W'(len_raw) > eff_budget) ? eff_budget[5:0] : len_raw;

    state_d = state_q;
    case (state_q)
      PASS:    if (take_stall) state_d = STALL;
      STALL:   if (!cfg_en || cnt_q == 6'd1) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q            <= PASS;
      k_q                <= '0;
      budget_q           <= '0;
      cnt_q              <= '0;
      stall_cycles_total <= '0;
      pkt_count          <= '0;
    end else begin
      state_q <= state_d;
      if (take_stall)  cnt_q <= stall_len;
      else if (stall)  cnt_q <= cnt_q - 6'd1;
      if (stall) begin
        if (budget_q != '0) budget_q <= budget_q - LEN_W'(1);
        if (stall_cycles_total != '1) stall_cycles_total <= stall_cycles_total + 32'd1;
      end else if (pkt_start) begin
        budget_q <= cfg_budget;
      end
      if (hs) begin
        if (s_tlast) begin
          k_q       <= '0;
          pkt_count <= pkt_count + 32'd1;
        end else begin
          k_q <= k_next;
        end
      end
    end
  end

  // Per-packet config snapshot; only meaningful once a packet has started
  always_ff @(posedge aclk) begin
    if (pkt_start) begin
      pkt_len_q <= cfg_pkt_len;
      max_len_q <= cfg_max_len;
      rate_q    <= cfg_rate;
      edge_en_q <= cfg_edge_en;
      force_q   <= cfg_force_edges;
    end
  end

endmodule

// File: tb/tb_axis_interruption_injector.sv
// Bench for axis_interruption_injector: directed packet scenarios plus a randomized run
// checked cycle by cycle against an integer reference model of the stall rules.
module tb_axis_interruption_injector;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata, m_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic        m_tvalid, m_tlast, m_tready;
  logic        cfg_en, cfg_edge_en, cfg_force_edges, cfg_seed_load;
  logic [15:0] cfg_pkt_len, cfg_budget, cfg_seed;
  logic [5:0]  cfg_max_len;
  logic [10:0] cfg_rate;
  logic        stall_active;
  logic [31:0] stall_cycles_total, pkt_count;

  int checks;
  int errors;

  axis_interruption_injector dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_tdata            (s_tdata),
    .s_tvalid           (s_tvalid),
    .s_tlast            (s_tlast),
    .s_tready           (s_tready),
    .m_tdata            (m_tdata),
    .m_tvalid           (m_tvalid),
    .m_tlast            (m_tlast),
    .m_tready           (m_tready),
    .cfg_en             (cfg_en),
    .cfg_pkt_len        (cfg_pkt_len),
    .cfg_budget         (cfg_budget),
    .cfg_max_len        (cfg_max_len),
    .cfg_rate           (cfg_rate),
    .cfg_edge_en        (cfg_edge_en),
    .cfg_force_edges    (cfg_force_edges),
    .cfg_seed           (cfg_seed),
    .cfg_seed_load      (cfg_seed_load),
    .stall_active       (stall_active),
    .stall_cycles_total (stall_cycles_total),
    .pkt_count          (pkt_count)
  );

  always #5 aclk = ~aclk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic set_cfg(input logic en, input int len, input int bud, input int ml,
                         input int rate, input logic edge_en, input logic frc);
    cfg_en          = en;
    cfg_pkt_len     = 16'(len);
    cfg_budget      = 16'(bud);
    cfg_max_len     = 6'(ml);
    cfg_rate        = 11'(rate);
    cfg_edge_en     = edge_en;
    cfg_force_edges = frc;
  endtask

  task automatic load_seed(input logic [15:0] s);
    cfg_seed      = s;
    cfg_seed_load = 1'b1;
    @(posedge aclk); #1;
    cfg_seed_load = 1'b0;
  endtask

  // Streams one packet with continuous valid/ready; mask bit b = a stall preceded beat b
  task automatic run_packet(input int len, output int cycles, output logic [63:0] mask,
                            output logic [255:0] trace);
    int beat;
    beat = 0; cycles = 0; mask = '0; trace = '0;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'hD000_0000;
    s_tlast  = (len == 1);
    while (beat < len && cycles < 250) begin
      @(negedge aclk);
      trace[cycles] = stall_active;
      cycles++;
      if (stall_active) mask[beat] = 1'b1;
      if (m_tvalid && m_tready) beat++;
      @(posedge aclk); #1;
      s_tdata = 32'hD000_0000 + 32'(beat);
      s_tlast = (beat == len - 1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    s_tvalid = 1'b1; m_tready = 1'b0; #3;
    checks++;
    if (stall_active !== 1'b0 || m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_gating: stall=%b m_tvalid=%b s_tready=%b, want 0 1 0",
               stall_active, m_tvalid, s_tready);
    end
    checks++;
    if (stall_cycles_total !== 32'd0 || pkt_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: total=%0d pkts=%0d, want 0 0", stall_cycles_total, pkt_count);
    end
    m_tready = 1'b1; #1;
    checks++;
    if (s_tready !== 1'b1 || m_tdata !== s_tdata) begin
      errors++;
      $display("FAIL reset_passthru: s_tready=%b m_tdata=%h, want 1 %h", s_tready, m_tdata, s_tdata);
    end
    s_tvalid = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_passthrough();
    int cyc; logic [63:0] mask; logic [255:0] tr; logic [31:0] p0;
    p0 = pkt_count;
    set_cfg(1'b0, 16, 50, 4, 1024, 1'b1, 1'b1);
    run_packet(16, cyc, mask, tr);
    checks++;
    if (cyc != 16 || mask != 64'd0) begin
      errors++;
      $display("FAIL passthrough: cycles=%0d stalls=%h, want 16 0", cyc, mask);
    end
    checks++;
    if (stall_cycles_total !== 32'd0 || pkt_count - p0 !== 32'd1) begin
      errors++;
      $display("FAIL passthrough_counters: total=%0d pkts=%0d, want 0 1", stall_cycles_total, pkt_count - p0);
    end
  endtask

  task automatic test_forced_edges(input int bud, input logic [63:0] exp_mask, input int exp_cyc);
    int cyc; logic [63:0] mask; logic [255:0] tr; logic [31:0] t0;
    t0 = stall_cycles_total;
    set_cfg(1'b1, 16, bud, 1, 0, 1'b1, 1'b1);
    run_packet(16, cyc, mask, tr);
    checks++;
    if (mask !== exp_mask) begin
      errors++;
      $display("FAIL forced_edges_b%0d_mask: got %h want %h", bud, mask, exp_mask);
    end
    checks++;
    if (cyc != exp_cyc || stall_cycles_total - t0 !== 32'(bud)) begin
      errors++;
      $display("FAIL forced_edges_b%0d_cycles: cycles=%0d stalls=%0d, want %0d %0d",
               bud, cyc, stall_cycles_total - t0, exp_cyc, bud);
    end
  endtask

  task automatic test_mid_and_seed();
    int cyc, cyc_a, cyc_b; logic [63:0] mask; logic [255:0] tr, tr_a, tr_b; logic [31:0] t0;
    t0 = stall_cycles_total;
    set_cfg(1'b1, 16, 100, 1, 1024, 1'b0, 1'b0);
    run_packet(16, cyc, mask, tr);
    checks++;
    if (mask !== 64'h1FF0 || cyc != 25 || stall_cycles_total - t0 !== 32'd9) begin
      errors++;
      $display("FAIL mid_always: mask=%h cycles=%0d stalls=%0d, want 1ff0 25 9",
               mask, cyc, stall_cycles_total - t0);
    end
    set_cfg(1'b1, 20, 20, 6, 512, 1'b1, 1'b0);
    load_seed(16'h1234);
    run_packet(20, cyc_a, mask, tr_a);
    load_seed(16'h1234);
    run_packet(20, cyc_b, mask, tr_b);
    checks++;
    if (tr_a !== tr_b || cyc_a != cyc_b || cyc_a >= 250) begin
      errors++;
      $display("FAIL seed_replay: cycles %0d vs %0d trace_a=%h trace_b=%h", cyc_a, cyc_b, tr_a[63:0], tr_b[63:0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] cur_d [24];
    logic [31:0] q_d [$];
    logic        q_l [$];
    logic [31:0] exp_d, t0, p0;
    logic [15:0] m_lfsr;
    logic        exp_l, medge, mforce, exp_stall, pedge, active, up_hs, dn_hs;
    int plen, pL, pbud, prate, pmax, src_idx, sent, done, cyc, nfail;
    int m_k, m_budget, m_rem, m_total, mL, mrate, mmax, nk, thr, len, p, r;
    t0 = stall_cycles_total; p0 = pkt_count;
    m_k = 0; m_budget = 0; m_rem = 0; m_total = 0; m_lfsr = '0;
    mL = 0; mrate = 0; mmax = 1; medge = 0; mforce = 0;
    plen = 1; pL = 1; pbud = 0; prate = 0; pmax = 1; pedge = 1'b1;
    src_idx = 0; sent = 0; done = 0; cyc = 0; nfail = 0; active = 1'b0;
    cfg_en = 1'b1;
    cfg_seed = 16'($urandom_range(1, 65535));
    cfg_seed_load = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    while (done < 100 && cyc < 20000) begin
      if (!active && sent < 100) begin
        plen = $urandom_range(1, 24);
        for (int i = 0; i < plen; i++) begin
          cur_d[i] = $urandom;
          q_d.push_back(cur_d[i]);
          q_l.push_back(i == plen - 1);
        end
        pL = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : plen;
        pbud = $urandom_range(0, 12); prate = $urandom_range(0, 1024);
        pmax = $urandom_range(1, 16); pedge = ($urandom_range(0, 3) != 0);
        active = 1'b1; src_idx = 0;
      end
      if (cyc > 0 && active && !s_tvalid) s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = cur_d[src_idx];
      s_tlast  = (src_idx == plen - 1);
      m_tready = ($urandom_range(0, 3) != 0);
      if (src_idx == 0) set_cfg(1'b1, pL, pbud, pmax, prate, pedge, 1'b1);
      else set_cfg(1'b1, $urandom_range(0, 30), $urandom_range(0, 40), $urandom_range(1, 16),
                   $urandom_range(0, 1024), 1'($urandom), 1'($urandom));
      @(negedge aclk);
      exp_stall = (m_rem > 0);
      checks++;
      if (stall_active !== exp_stall || m_tvalid !== (s_tvalid & ~exp_stall) ||
          s_tready !== (m_tready & ~exp_stall)) begin
        errors++; nfail++;
        if (nfail <= 5)
          $display("FAIL random_gating cyc=%0d: stall=%b mv=%b sr=%b, want stall=%b", cyc,
                   stall_active, m_tvalid, s_tready, exp_stall);
      end
      if (exp_stall) begin
        m_rem--; m_budget--; m_total++;
      end else if (s_tvalid && m_tready) begin
        if (m_k == 0) begin
          mL = int'(cfg_pkt_len); m_budget = int'(cfg_budget); mrate = int'(cfg_rate);
          mmax = int'(cfg_max_len); medge = cfg_edge_en; mforce = cfg_force_edges;
        end
        if (s_tlast) m_k = 0;
        else begin
          nk = (m_k == 65535) ? m_k : m_k + 1;
          p = int'(m_lfsr[9:0]); r = int'(m_lfsr[15:10]);
          thr = 0; len = 1;
          if (medge && nk >= 1 && nk <= 3) thr = mforce ? 1024 : (64 << nk);
          else if (medge && nk >= mL - 3 && nk <= mL - 1) thr = mforce ? 1024 : 512;
          else if (nk >= 4 && nk <= mL - 4) begin thr = mrate; len = 1 + r % mmax; end
          if (p < thr && m_budget > 0) m_rem = (len < m_budget) ? len : m_budget;
          m_k = nk;
        end
      end
      m_lfsr = cfg_seed_load ? ((cfg_seed == 0) ? 16'hACE1 : cfg_seed) : lfsr_next(m_lfsr);
      up_hs = s_tvalid && s_tready;
      dn_hs = m_tvalid && m_tready;
      if (dn_hs) begin
        exp_d = (q_d.size() > 0) ? q_d.pop_front() : 32'hxxxx_xxxx;
        exp_l = (q_l.size() > 0) ? q_l.pop_front() : 1'bx;
        checks++;
        if (m_tdata !== exp_d || m_tlast !== exp_l || stall_active !== 1'b0) begin
          errors++; nfail++;
          if (nfail <= 5)
            $display("FAIL random_beat cyc=%0d: data=%h last=%b stall=%b, want %h %b 0",
                     cyc, m_tdata, m_tlast, stall_active, exp_d, exp_l);
        end
        if (m_tlast) done++;
      end
      @(posedge aclk); #1;
      cfg_seed_load = 1'b0;
      if (up_hs) begin
        s_tvalid = 1'b0;
        src_idx++;
        if (src_idx == plen) begin active = 1'b0; sent++; src_idx = 0; end
      end
      cyc++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++;
    if (done != 100 || pkt_count - p0 !== 32'd100) begin
      errors++;
      $display("FAIL random_pkts: seen=%0d pkt_count=%0d, want 100 100", done, pkt_count - p0);
    end
    checks++;
    if (stall_cycles_total - t0 !== 32'(m_total)) begin
      errors++;
      $display("FAIL random_stall_total: got %0d want %0d", stall_cycles_total - t0, m_total);
    end
  endtask

  task automatic test_reset_mid_stall();
    int beat, cyc; logic found; logic [63:0] mask; logic [255:0] tr;
    set_cfg(1'b1, 16, 100, 16, 1024, 1'b0, 1'b0);
    beat = 0; found = 1'b0;
    s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = 32'hE000_0000; s_tlast = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge aclk);
      if (stall_active) found = 1'b1;
      else begin
        if (m_tvalid) beat++;
        @(posedge aclk); #1;
        s_tdata = 32'hE000_0000 + 32'(beat);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_stall_entry: stall_active never rose, want a mid stall");
    end
    #1 aresetn = 1'b0;
    #1;
    checks++;
    if (stall_active !== 1'b0 || m_tvalid !== 1'b1 || s_tready !== 1'b1 ||
        stall_cycles_total !== 32'd0 || pkt_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_stall: stall=%b mv=%b sr=%b total=%0d pkts=%0d, want 0 1 1 0 0",
               stall_active, m_tvalid, s_tready, stall_cycles_total, pkt_count);
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    set_cfg(1'b1, 8, 1, 1, 0, 1'b1, 1'b1);
    run_packet(8, cyc, mask, tr);
    checks++;
    if (mask !== 64'h2 || cyc != 9 || pkt_count !== 32'd1) begin
      errors++;
      $display("FAIL reset_restart: mask=%h cycles=%0d pkts=%0d, want 2 9 1", mask, cyc, pkt_count);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    aresetn = 1'b0;
    s_tdata = 32'h0BAD_F00D; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    cfg_seed = 16'h0; cfg_seed_load = 1'b0;
    set_cfg(1'b0, 16, 0, 1, 0, 1'b0, 1'b0);
    test_reset();
    test_passthrough();
    test_forced_edges(6, 64'hE00E, 22);
    test_forced_edges(4, 64'h200E, 20);
    test_mid_and_seed();
    test_random();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
